// File: rtl/mima_word_tx.sv
// Outbound word serializer: sends WORD_W-bit core words to an external host as bytes
// over the dedicated output pins, one four-phase strobe/ack handshake per byte.
module mima_word_tx #(
   parameter int WORD_W    = 24,
   parameter int MSB_FIRST = 1,
   parameter int SETUP_CYC = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic [7:0]        byte_out,
   output logic              byte_stb,
   input  logic              byte_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              err_clr
);

   localparam int NB = WORD_W / 8;
   localparam int CW = $clog2(NB + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STB_HI = 2'd2,
      STB_LO = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TW-1:0]     ph_q, ph_d;
   logic [7:0]        byte_out_q, byte_out_d;
   logic              byte_stb_q, byte_stb_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              ack_m_q, ack_s_q;
   logic              timeout_s;
   logic              last_s;
   logic              setup_ok_s;
   logic              ph_at_to_s;

   // The byte currently presented on the pins sits at the head of the shift register.
   function automatic logic [7:0] head_byte(input logic [WORD_W-1:0] w);
      if (MSB_FIRST != 0) begin
         head_byte = w[WORD_W-1 -: 8];
      end else begin
         head_byte = w[7:0];
      end
   endfunction

   function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
      if (MSB_FIRST != 0) begin
         next_word = w << 8;
      end else begin
         next_word = w >> 8;
      end
   endfunction

   assign last_s     = (cnt_q == CW'(1));
   assign setup_ok_s = (int'(ph_q) >= SETUP_CYC - 1);
   assign ph_at_to_s = (ph_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timeout_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (word_valid) begin
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            // A host holding ack high keeps us here; only the phase timeout ends the wait.
            if (setup_ok_s && !ack_s_q) begin
               state_d = STB_HI;
            end else if (ph_at_to_s) begin
               state_d   = IDLE;
               timeout_s = 1'b1;
            end else begin
               state_d = SETUP;
            end
         end
         STB_HI: begin
            if (ack_s_q) begin
               state_d = STB_LO;
            end else if (ph_at_to_s) begin
               state_d   = IDLE;
               timeout_s = 1'b1;
            end else begin
               state_d = STB_HI;
            end
         end
         STB_LO: begin
            if (!ack_s_q) begin
               state_d = last_s ? IDLE : SETUP;
            end else if (ph_at_to_s) begin
               state_d   = IDLE;
               timeout_s = 1'b1;
            end else begin
               state_d = STB_LO;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      byte_out_d = byte_out_q;
      byte_stb_d = (state_d == STB_HI);
      done_d     = (state_q == STB_LO) && (state_d == IDLE) && !timeout_s;
      if ((state_d != state_q) || (state_q == IDLE)) begin
         ph_d = '0;
      end else begin
         ph_d = ph_q + TW'(1);
      end
      if ((state_q == IDLE) && word_valid) begin
         shift_d    = word_in;
         cnt_d      = CW'(NB);
         byte_out_d = head_byte(word_in);
      end else if ((state_q == STB_LO) && !ack_s_q && !last_s) begin
         shift_d    = next_word(shift_q);
         cnt_d      = cnt_q - CW'(1);
         byte_out_d = head_byte(next_word(shift_q));
      end else begin
         shift_d = shift_q;
      end
      if (err_clr) begin
         err_d = 1'b0;
      end else if (timeout_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q    <= '0;
         cnt_q      <= '0;
         ph_q       <= '0;
         byte_out_q <= 8'h00;
         byte_stb_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ack_m_q    <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         ph_q       <= ph_d;
         byte_out_q <= byte_out_d;
         byte_stb_q <= byte_stb_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ack_m_q    <= byte_ack;
         ack_s_q    <= ack_m_q;
      end
   end

   assign word_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign byte_out   = byte_out_q;
   assign byte_stb   = byte_stb_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
